// File: rtl/bit_block_generator_if.sv
// Request/response bundle between a requester and the bit block generator.
// req is taken only while busy=0; data/err are meaningful only while data_enb=1.
interface bit_block_generator_if #(
    parameter int DATA_B_W = 32,
    parameter int CNT_B_W  = 4
);
    logic                req;
    logic [CNT_B_W-1:0]  req_cnt;
    logic [1:0]          run_len;
    logic [DATA_B_W-1:0] data;
    logic                data_enb;
    logic                busy;
    logic                err;

    modport master (
        output req, req_cnt, run_len,
        input  data, data_enb, busy, err
    );

    modport slave (
        input  req, req_cnt, run_len,
        output data, data_enb, busy, err
    );
endinterface

// File: rtl/bit_block_generator.sv
// Builds a word of N blocks of L consecutive 1s (single-0 separated, packed from
// bit 0), one block per clock, then presents it with a one-cycle data_enb strobe.
module bit_block_generator #(
    parameter int DATA_B_W = 32,
    parameter int CNT_B_W  = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    bit_block_generator_if.slave   bus,
    output logic [1:0]             state_dbg
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUILD = 2'd1,
        OUT   = 2'd2
    } state_t;

    // Capacity per run-length code: floor((DATA_B_W+1)/(L+1)), folded at elaboration.
    localparam logic [31:0] CAP_L1 = 32'((DATA_B_W + 1) / 2);
    localparam logic [31:0] CAP_L2 = 32'((DATA_B_W + 1) / 3);
    localparam logic [31:0] CAP_L3 = 32'((DATA_B_W + 1) / 4);
    localparam logic [31:0] CAP_L4 = 32'((DATA_B_W + 1) / 5);
    localparam logic [CNT_B_W-1:0] CNT_ONE = CNT_B_W'(1);

    state_t              state;
    logic [1:0]          len_code;
    logic [5:0]          ptr;
    logic [CNT_B_W-1:0]  remaining;

    logic [31:0]         req_cap;
    logic                req_over;
    logic [CNT_B_W-1:0]  n_eff;
    logic [3:0]          blk_base;
    logic [DATA_B_W-1:0] blk_mask;

    function automatic logic [31:0] cap_of(input logic [1:0] code);
        case (code)
            2'd0:    return CAP_L1;
            2'd1:    return CAP_L2;
            2'd2:    return CAP_L3;
            default: return CAP_L4;
        endcase
    endfunction

    always_comb begin
        req_cap  = cap_of(bus.run_len);
        req_over = {{(32-CNT_B_W){1'b0}}, bus.req_cnt} > req_cap;
        n_eff    = req_over ? req_cap[CNT_B_W-1:0] : bus.req_cnt;

        case (len_code)
            2'd0:    blk_base = 4'b0001;
            2'd1:    blk_base = 4'b0011;
            2'd2:    blk_base = 4'b0111;
            default: blk_base = 4'b1111;
        endcase
        blk_mask = {{(DATA_B_W-4){1'b0}}, blk_base} << ptr;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            len_code     <= 2'd0;
            ptr          <= 6'd0;
            remaining    <= '0;
            bus.data     <= '0;
            bus.data_enb <= 1'b0;
            bus.busy     <= 1'b0;
            bus.err      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req) begin
                        len_code  <= bus.run_len;
                        ptr       <= 6'd0;
                        remaining <= n_eff;
                        bus.data  <= '0;
                        bus.err   <= req_over;
                        bus.busy  <= 1'b1;
                        // An empty request skips straight to the strobe.
                        if (n_eff == '0) begin
                            state        <= OUT;
                            bus.data_enb <= 1'b1;
                        end else begin
                            state <= BUILD;
                        end
                    end
                end
                BUILD: begin
                    bus.data  <= bus.data | blk_mask;
                    ptr       <= ptr + {4'b0000, len_code} + 6'd2;
                    remaining <= remaining - CNT_ONE;
                    if (remaining == CNT_ONE) begin
                        state        <= OUT;
                        bus.data_enb <= 1'b1;
                    end
                end
                OUT: begin
                    bus.data_enb <= 1'b0;
                    bus.busy     <= 1'b0;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign state_dbg = state;

endmodule
